regfile_write_arbiter: RTL

//  8x4 register file with two write ports, each using a valid/ready handshake.

---
 rtl/regfile_write_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// 8x4 register file with two valid/ready write ports, round-robin collision arbitration,
// a sequenced multi-cycle clear and two combinational read ports.
// Optional accepted-write counters are built when REGFILE_WR_COUNT_EN is defined.
module regfile_write_arbiter #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS),
  parameter int unsigned DW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr1_valid,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_ready,
  input  logic          wr2_valid,
  input  logic [AW-1:0] wr2_addr,
  input  logic [DW-1:0] wr2_data,
  output logic          wr2_ready,
  input  logic          clr,
  output logic          busy,
  input  logic [AW-1:0] rd_addr_1,
  output logic [DW-1:0] rd_data_1,
  input  logic [AW-1:0] rd_addr_2,
  output logic [DW-1:0] rd_data_2,
  output logic          conflict,
  output logic          pri,
  output logic [7:0]    wr_cnt_1,
  output logic [7:0]    wr_cnt_2
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic [DW-1:0] regs [NREGS];
  logic          idle;
  logic          same_addr;
  logic          acc1;
  logic          acc2;

  // The port that loses a same-address collision is held off; pri names the winner.
  assign idle      = (state == IDLE);
  assign same_addr = (wr1_addr == wr2_addr);
  assign wr1_ready = idle && !(wr2_valid && same_addr && pri);
  assign wr2_ready = idle && !(wr1_valid && same_addr && !pri);
  assign conflict  = idle && wr1_valid && wr2_valid && same_addr;
  assign acc1      = wr1_valid && wr1_ready;
  assign acc2      = wr2_valid && wr2_ready;
  assign busy      = (state == CLEAR);

  assign rd_data_1 = regs[rd_addr_1];
  assign rd_data_2 = regs[rd_addr_2];

  // Write commit, arbitration pointer and clear sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clr_ptr <= '0;
      pri     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc1) regs[wr1_addr] <= wr1_data;
          if (acc2) regs[wr2_addr] <= wr2_data;
          if (conflict) pri <= ~pri;
          if (clr) state <= CLEAR;
        end
        CLEAR: begin
          regs[clr_ptr] <= '0;
          clr_ptr       <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(NREGS - 1)) begin
            state   <= IDLE;
            clr_ptr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REGFILE_WR_COUNT_EN
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  // Saturating per-port accepted-write counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1 <= 8'h00;
      cnt2 <= 8'h00;
    end else begin
      if (acc1 && (cnt1 != 8'hFF)) cnt1 <= cnt1 + 8'd1;
      if (acc2 && (cnt2 != 8'hFF)) cnt2 <= cnt2 + 8'd1;
    end
  end

  assign wr_cnt_1 = cnt1;
  assign wr_cnt_2 = cnt2;
`else
  assign wr_cnt_1 = 8'h00;
  assign wr_cnt_2 = 8'h00;
`endif

endmodule
